// File: rtl/ariane_pkg.sv
// Shared core package, RVFI-DII section.
// Holds the host command bundle and the feeder state encoding.
package ariane_pkg;

  typedef struct packed {
    logic        cmd;
    logic [31:0] insn;
    logic [15:0] insn_time;
  } rvfi_dii_cmd_t;

  typedef enum logic [1:0] {
    DII_RUN,
    DII_DRAIN,
    DII_CORE_RST
  } rvfi_dii_state_e;

endpackage

// File: rtl/config_pkg.sv
// Core configuration slice: only the fields this block can see.
// The empty config is the default when no core parameters are needed.
package config_pkg;

  typedef struct packed {
    logic [31:0] xlen;
    logic [31:0] nr_commit_ports;
  } cva6_cfg_t;

  localparam cva6_cfg_t cva6_cfg_empty = '0;

endpackage

// File: rtl/fifo_v3.sv
// Power-of-two circular FIFO, no fall-through.
// Synchronous active-high reset plus synchronous flush.
module fifo_v3 #(
  parameter int unsigned DEPTH = 4,
  parameter type         dtype = logic
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic flush_i,
  output logic full_o,
  output logic empty_o,
  input  dtype data_i,
  input  logic push_i,
  output dtype data_o,
  input  logic pop_i
);

  localparam int unsigned AW = $clog2(DEPTH);

  dtype          mem_q [DEPTH];
  logic [AW-1:0] rd_q;
  logic [AW-1:0] wr_q;
  logic [AW:0]   cnt_q;
  logic          do_push;
  logic          do_pop;

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign data_o  = mem_q[rd_q];

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      if (do_push && !do_pop)
        cnt_q <= cnt_q + (AW+1)'(1);
      else if (!do_push && do_pop)
        cnt_q <= cnt_q - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end

endmodule

// File: rtl/rvfi_dii_inst_feeder.sv
// RVFI-DII instruction feeder: buffers host instructions for fetch,
// drains on end-of-trace, then pulses the core reset.
module rvfi_dii_inst_feeder
  import ariane_pkg::*;
#(
  parameter config_pkg::cva6_cfg_t CVA6Cfg = config_pkg::cva6_cfg_empty,
  parameter type rvfi_dii_inst_pack_t = logic,
  parameter int unsigned DEPTH         = 4,
  parameter int unsigned RST_CYCLES    = 8,
  parameter int unsigned DRAIN_TIMEOUT = 1024
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                host_cmd_valid_i,
  output logic                host_cmd_ready_o,
  input  rvfi_dii_cmd_t       host_cmd_i,
  output logic                rvfi_dii_rtrn_vld_o,
  output rvfi_dii_inst_pack_t rvfi_dii_inst_pack_o,
  input  logic                rvfi_dii_data_ready_i,
  input  logic [1:0]          retire_cnt_i,
  output logic                core_rst_o,
  output logic                trace_done_o,
  output logic                trace_timeout_o
);

  localparam int unsigned TMAX =
    (DRAIN_TIMEOUT > RST_CYCLES) ? DRAIN_TIMEOUT : RST_CYCLES;
  localparam int unsigned TW = (TMAX > 2) ? $clog2(TMAX) : 1;

  rvfi_dii_state_e state_q, state_d;
  logic [15:0]     issued_q, retired_q;
  logic [TW-1:0]   timer_q, timer_d;
  logic            fifo_full, fifo_empty;
  logic            push, pop, flush;
  logic [31:0]     head_insn;
  logic            drain_eq, drain_to;

  fifo_v3 #(
    .DEPTH (DEPTH),
    .dtype (logic [31:0])
  ) i_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (flush),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .data_i  (host_cmd_i.insn),
    .push_i  (push),
    .data_o  (head_insn),
    .pop_i   (pop)
  );

  // rvfi_insn is expected to occupy the low 32 bits of the packet
  assign rvfi_dii_inst_pack_o = rvfi_dii_inst_pack_t'(head_insn);
  assign pop = rvfi_dii_rtrn_vld_o & rvfi_dii_data_ready_i;

  assign drain_eq = (retired_q == issued_q);
  assign drain_to = (timer_q == TW'(DRAIN_TIMEOUT - 1));

  always_comb begin
    state_d             = state_q;
    timer_d             = timer_q;
    host_cmd_ready_o    = 1'b0;
    rvfi_dii_rtrn_vld_o = 1'b0;
    core_rst_o          = 1'b0;
    trace_done_o        = 1'b0;
    trace_timeout_o     = 1'b0;
    push                = 1'b0;
    flush               = 1'b0;
    unique case (state_q)
      DII_RUN: begin
        host_cmd_ready_o    = ~fifo_full;
        rvfi_dii_rtrn_vld_o = ~fifo_empty;
        if (host_cmd_valid_i && !fifo_full) begin
          if (host_cmd_i.cmd) begin
            push = 1'b1;
          end else begin
            state_d = DII_DRAIN;
            timer_d = '0;
          end
        end
      end
      DII_DRAIN: begin
        rvfi_dii_rtrn_vld_o = ~fifo_empty;
        if (drain_eq || drain_to) begin
          // a reset landing on the exit cycle suppresses the pulse
          trace_done_o    = ~rst_i;
          trace_timeout_o = ~rst_i & ~drain_eq;
          flush           = 1'b1;
          timer_d         = '0;
          state_d         = DII_CORE_RST;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      DII_CORE_RST: begin
        core_rst_o = 1'b1;
        if (timer_q == TW'(RST_CYCLES - 1)) begin
          timer_d = '0;
          state_d = DII_RUN;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: state_d = DII_RUN;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= DII_RUN;
      timer_q   <= '0;
      issued_q  <= '0;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      if (flush) begin
        issued_q  <= '0;
        retired_q <= '0;
      end else begin
        if (push) issued_q <= issued_q + 16'd1;
        if (state_q != DII_CORE_RST)
          retired_q <= retired_q + {14'd0, retire_cnt_i};
      end
    end
  end

  logic unused_ok;
  assign unused_ok = ^{host_cmd_i.insn_time, CVA6Cfg};

endmodule

// File: tb/tb_rvfi_dii_inst_feeder.sv
// Scoreboard bench for rvfi_dii_inst_feeder: packets checked in order,
// drain length and core reset length predicted from counts.
module tb_rvfi_dii_inst_feeder;
  import ariane_pkg::*;

  localparam int DEPTH = 4;
  localparam int RSTC  = 8;
  localparam int DT    = 1024;

  typedef struct packed {
    logic [31:0] rvfi_insn;
  } pack_t;

  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic          host_cmd_valid = 1'b0;
  logic          host_cmd_ready;
  rvfi_dii_cmd_t host_cmd = '0;
  logic          vld;
  pack_t         pack;
  logic          data_ready = 1'b0;
  logic [1:0]    retire_cnt = 2'd0;
  logic          core_rst;
  logic          done;
  logic          tmo;

  always #5 clk = ~clk;

  rvfi_dii_inst_feeder #(
    .CVA6Cfg              (config_pkg::cva6_cfg_empty),
    .rvfi_dii_inst_pack_t (pack_t),
    .DEPTH                (DEPTH),
    .RST_CYCLES           (RSTC),
    .DRAIN_TIMEOUT        (DT)
  ) dut (
    .clk_i                 (clk),
    .rst_i                 (rst_i),
    .host_cmd_valid_i      (host_cmd_valid),
    .host_cmd_ready_o      (host_cmd_ready),
    .host_cmd_i            (host_cmd),
    .rvfi_dii_rtrn_vld_o   (vld),
    .rvfi_dii_inst_pack_o  (pack),
    .rvfi_dii_data_ready_i (data_ready),
    .retire_cnt_i          (retire_cnt),
    .core_rst_o            (core_rst),
    .trace_done_o          (done),
    .trace_timeout_o       (tmo)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  int          n_pop   = 0;
  int          issued  = 0;
  int          retired = 0;
  bit          rand_ready = 0;
  logic [31:0] exp_q[$];
  logic        mon_stall = 1'b0;
  logic [31:0] mon_held  = '0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // monitor: every handshake pops the oldest expected instruction
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (rst_i) begin
        mon_stall = 1'b0;
      end else begin
        if (mon_stall && vld)
          check("head_stable", pack.rvfi_insn, mon_held);
        if (tmo && !done)
          check("timeout_qual", 32'(tmo), 0);
        if (vld && data_ready) begin
          n_pop++;
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL pkt_extra: got %0h expected none",
                     pack.rvfi_insn);
          end else begin
            e = exp_q.pop_front();
            check("pkt_order", pack.rvfi_insn, e);
          end
        end
        mon_stall = vld && !data_ready;
        mon_held  = pack.rvfi_insn;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (rand_ready) data_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send(input logic c, input logic [31:0] insn);
    bit ok;
    int n;
    ok = 0;
    n  = 0;
    host_cmd_valid     = 1'b1;
    host_cmd.cmd       = c;
    host_cmd.insn      = insn;
    host_cmd.insn_time = 16'($urandom);
    while (!ok && n < 200) begin
      @(negedge clk);
      if (host_cmd_ready) begin
        ok = 1;
        if (c) begin
          exp_q.push_back(insn);
          issued++;
        end
      end
      tick();
      n++;
    end
    host_cmd_valid = 1'b0;
    if (!ok) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout: cmd %0h not accepted", insn);
    end
  endtask

  task automatic retire(input int k);
    int rc;
    while (k > 0) begin
      rc = (k >= 2) ? 2 : k;
      retire_cnt = 2'(rc);
      retired += rc;
      k -= rc;
      tick();
    end
    retire_cnt = 2'd0;
  endtask

  task automatic wait_sb();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      tick();
      n++;
    end
    check("sb_empty", 32'(exp_q.size()), 0);
  endtask

  // predicted drain: outstanding work retired two per cycle, else timeout
  task automatic end_trace(input bit ret);
    int r, exp_cyc, cyc;
    bit exp_to, seen;
    r = issued - retired;
    if (r == 0) begin
      exp_cyc = 0;
      exp_to  = 0;
    end else if (ret && (r + 1) / 2 <= DT - 1) begin
      exp_cyc = (r + 1) / 2;
      exp_to  = 0;
    end else begin
      exp_cyc = DT - 1;
      exp_to  = 1;
    end
    send(1'b0, 32'h0);
    cyc  = 0;
    seen = 0;
    while (!seen && cyc < DT + 20) begin
      if (ret && r > 0) begin
        retire_cnt = (r >= 2) ? 2'd2 : 2'(r);
        r -= int'(retire_cnt);
      end else begin
        retire_cnt = 2'd0;
      end
      @(negedge clk);
      if (done) begin
        seen = 1;
        check("drain_len", cyc, exp_cyc);
        check("drain_timeout", 32'(tmo), 32'(exp_to));
      end
      tick();
      cyc++;
    end
    retire_cnt = 2'd0;
    if (!seen) begin
      n_tests++;
      n_fail++;
      $display("FAIL done_missing: no trace_done after %0d cycles", cyc);
    end
    exp_q.delete();
    issued  = 0;
    retired = 0;
  endtask

  task automatic core_phase(input int abort_at);
    int cnt;
    bit fin;
    cnt = 0;
    fin = 0;
    while (!fin && cnt < RSTC + 20) begin
      if (abort_at != 0 && cnt == abort_at - 1) begin
        rst_i = 1'b1;
        @(negedge clk);
        check("abort_no_done", 32'(done), 0);
        tick();
        rst_i = 1'b0;
        exp_q.delete();
        issued  = 0;
        retired = 0;
        @(negedge clk);
        check("abort_core_rst", 32'(core_rst), 0);
        check("abort_ready", 32'(host_cmd_ready), 1);
        check("abort_done", 32'(done), 0);
        tick();
        return;
      end
      @(negedge clk);
      if (!core_rst) begin
        fin = 1;
      end else begin
        cnt++;
        if (cnt == 1) check("crst_vld", 32'(vld), 0);
        tick();
      end
    end
    check("core_rst_len", cnt, RSTC);
    check("run_ready", 32'(host_cmd_ready), 1);
    check("run_no_done", 32'(done), 0);
    tick();
  endtask

  initial begin
    int n;
    tick();
    tick();
    @(negedge clk);
    check("rst_ready", 32'(host_cmd_ready), 1);
    check("rst_vld", 32'(vld), 0);
    check("rst_core_rst", 32'(core_rst), 0);
    check("rst_done", 32'(done), 0);
    check("rst_timeout", 32'(tmo), 0);
    tick();
    rst_i = 1'b0;

    // three nops, one-cycle push-to-valid latency
    data_ready         = 1'b1;
    host_cmd_valid     = 1'b1;
    host_cmd.cmd       = 1'b1;
    host_cmd.insn      = 32'h0000_0013;
    host_cmd.insn_time = 16'h0;
    @(negedge clk);
    check("vld_pre_push", 32'(vld), 0);
    if (host_cmd_ready) begin
      exp_q.push_back(32'h0000_0013);
      issued++;
    end
    tick();
    host_cmd_valid = 1'b0;
    @(negedge clk);
    check("vld_latency", 32'(vld), 1);
    tick();
    send(1'b1, 32'h0000_0013);
    send(1'b1, 32'h0000_0013);
    wait_sb();
    check("nop_pkts", n_pop, 3);
    end_trace(1'b1);
    core_phase(0);

    // fill with generator stalled, then hold a fifth command
    data_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) send(1'b1, 32'h1000_0000 + i);
    @(negedge clk);
    check("full_ready", 32'(host_cmd_ready), 0);
    check("full_vld", 32'(vld), 1);
    tick();
    host_cmd_valid = 1'b1;
    host_cmd.cmd   = 1'b1;
    host_cmd.insn  = 32'h1000_0004;
    repeat (5) tick();
    @(negedge clk);
    check("held_ready", 32'(host_cmd_ready), 0);
    check("held_head", pack.rvfi_insn, 32'h1000_0000);
    tick();
    data_ready = 1'b1;
    @(negedge clk);
    check("full_pop_ready", 32'(host_cmd_ready), 0);
    tick();
    send(1'b1, 32'h1000_0004);
    wait_sb();
    end_trace(1'b0);
    core_phase(0);

    // two instructions retired together during drain
    send(1'b1, 32'h2000_0001);
    send(1'b1, 32'h2000_0002);
    wait_sb();
    end_trace(1'b1);
    core_phase(0);

    // reset in the middle of the core reset pulse
    send(1'b1, 32'h3000_0001);
    retire(1);
    end_trace(1'b0);
    core_phase(3);

    // reset on the very cycle the drain would finish
    send(1'b1, 32'h4000_0001);
    retire(1);
    wait_sb();
    send(1'b0, 32'h0);
    rst_i = 1'b1;
    @(negedge clk);
    check("drain_abort_done", 32'(done), 0);
    tick();
    rst_i = 1'b0;
    exp_q.delete();
    issued  = 0;
    retired = 0;
    @(negedge clk);
    check("drain_abort_crst", 32'(core_rst), 0);
    check("drain_abort_ready", 32'(host_cmd_ready), 1);
    tick();

    // random traces with a randomly stalling generator
    rand_ready = 1;
    for (int t = 0; t < 6; t++) begin
      n = $urandom_range(1, 10);
      for (int i = 0; i < n; i++) send(1'b1, $urandom);
      if ($urandom_range(0, 1) == 1)
        retire($urandom_range(0, issued - retired));
      end_trace(1'b1);
      core_phase(0);
    end
    rand_ready = 0;
    data_ready = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
